draw_pieces: RTL and testbench
==============================

DRAW_PIECES -- requirements
Module: draw_pieces

Interface
REQ-001 SHALL have port clk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port board_we, input, 1 bit: write strobe into the shadow board.
REQ-004 SHALL have port board_addr, input, 6 bits: square index, row*8+col; row 0 is the top row, col 0 is the left column.
REQ-005 SHALL have port board_data, input, 4 bits: piece code to write.
REQ-006 SHALL have port sel_valid, input, 1 bit: highlight enable.
REQ-007 SHALL have port sel_addr, input, 6 bits: square to highlight, same indexing as board_addr.
REQ-008 SHALL have port vga_in, vga_if.in: timing and rgb from the board/background stage.
REQ-009 SHALL have port vga_out, vga_if.out: timing and rgb with pieces overlaid.

Function
REQ-010 SHALL define piece codes as: 0 empty; 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; bit3 set = black; 7 and 8 to 15 with low bits 0 or 7 render as empty.
REQ-011 SHALL define the board area as hcount 256..767 and vcount 128..639, made of 8x8 squares of 64x64 pixels.
  - col = (hcount-256)>>6; row = (vcount-128)>>6.
  - local x = (hcount-256)%64; local y = (vcount-128)%64.
REQ-012 SHALL keep two 64-entry x 4-bit boards: a shadow board written by the write port, and an active board used for rendering.
REQ-013 SHALL write board_data into shadow[board_addr] on any cycle with board_we=1; the write is visible in the shadow on the next cycle.
REQ-014 SHALL copy the shadow board into the active board in the cycle after a rising edge of vga_in.vblnk, so the whole board changes only between frames.
REQ-015 SHALL handle a write in the same cycle as the copy as follows: the write lands in the shadow only and is rendered from the following frame.
REQ-016 SHALL also capture sel_valid/sel_addr into rendering registers at the same copy event.
REQ-017 SHALL have a fixed 3-cycle pipeline, vga_in to vga_out, for every field:
  - S1: compute row/col/local x/y and register the active-board piece code.
  - S2: drive the piece_rom address and register the 1-bit mask.
  - S3: register the output.
REQ-018 SHALL delay vcount, vsync, vblnk, hcount, hsync, hblnk and rgb by exactly 3 cycles, unmodified.
REQ-019 SHALL choose output rgb (of the aligned pixel) in this priority order:
  - blanking (hblnk or vblnk): pass the delayed rgb;
  - outside the board area: pass the delayed rgb;
  - captured sel_valid=1, pixel in the captured selected square, and local x or local y in {0,1,62,63}: 12'hF_0_0;
  - nonempty piece with mask=1: 12'hF_F_F for white, 12'h0_0_0 for black;
  - otherwise: pass the delayed rgb.
REQ-020 SHALL address piece_rom as {type-1 (3 bits), local y (6), local x (6)}, i.e. 15 bits, giving 6x64x64 one-bit masks.
REQ-021 SHALL use the boundary pixels exactly: hcount 255/768 and vcount 127/640 are outside the board; 256/767 and 128/639 are inside.

Reset
REQ-022 SHALL zero all vga_out fields on the cycle after rst=1 and keep them zero while rst is held.
REQ-023 SHALL load both boards with the standard start position on reset:
  - row 0: 12,10,11,13,14,11,10,12;
  - row 1: 9;
  - rows 2-5: 0;
  - row 6: 1;
  - row 7: 4,2,3,5,6,3,2,4.
REQ-024 SHALL clear the captured selection to sel_valid=0 on reset, along with the internal pipeline registers.
REQ-025 SHALL, when reset is asserted mid-frame, discard any pending shadow writes and restore the start position; output resumes 3 cycles after rst deasserts.

Structure
REQ-026 SHALL place piece_t codes, BOARD_X0=256, BOARD_Y0=128, SQUARE=64 and the start-position table in a shared package chess_pkg; VGA timing constants stay in vga_pkg.
REQ-027 SHALL have exactly one sub-module, piece_rom: a synchronous-read ROM, 32768x1, initialised from a file, 1-cycle read latency.

Verification
REQ-028 SHALL verify reset: after rst, the first frame at square (0,0), pixel hcount=288, vcount=160, with the rook mask bit=1 -> vga_out.rgb=12'h0_0_0, 3 cycles later.
REQ-029 SHALL verify latency: drive any vga_in sequence -> vga_out timing equals vga_in delayed exactly 3 cycles; rgb in blanking equals input rgb.
REQ-030 SHALL verify frame-synchronous update: write addr 36 data 5 mid-frame -> square (4,4) is unchanged for the rest of that frame and shows the white queen mask from the next frame.
REQ-031 SHALL verify the simultaneous write and copy: write addr 0 data 0 in the exact copy cycle -> square 0 still shows the black rook next frame and is empty the frame after.
REQ-032 SHALL verify highlight: sel_valid=1, sel_addr=63 -> pixels (hcount 704 or 767, vcount 600) and (hcount 730, vcount 576/577) are 12'hF_0_0; pixel (730,600) follows the piece/background rule.
REQ-033 SHALL verify the board edges: an empty board with input rgb 12'h8_8_8 at hcount 255 and 768 -> output rgb 12'h8_8_8; a selection on square 0 colours hcount 256, vcount 128.

Source files
------------

// File: rtl/chess_pkg.sv
// Chess piece codes, board geometry and the start position.
package chess_pkg;

    // Low three bits of a square code; bit 3 marks a black piece.
    typedef enum logic [2:0] {
        PcEmpty  = 3'd0,
        PcPawn   = 3'd1,
        PcKnight = 3'd2,
        PcBishop = 3'd3,
        PcRook   = 3'd4,
        PcQueen  = 3'd5,
        PcKing   = 3'd6
    } piece_t;

    localparam int unsigned BLACK_BIT  = 3;
    localparam int unsigned BOARD_X0   = 256;
    localparam int unsigned BOARD_Y0   = 128;
    localparam int unsigned SQUARE     = 64;
    localparam int unsigned BOARD_SIZE = 8 * SQUARE;

    // Indexed row*8+col, row 0 at the top (black back rank).
    localparam logic [3:0] START_POS [64] = '{
        4'd12, 4'd10, 4'd11, 4'd13, 4'd14, 4'd11, 4'd10, 4'd12,
        4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,  4'd9,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,
        4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,
        4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,
        4'd4,  4'd2,  4'd3,  4'd5,  4'd6,  4'd3,  4'd2,  4'd4
    };

    // Codes 0 and 7 (either colour) draw nothing.
    function automatic logic is_piece(input logic [2:0] kind);
        return (kind >= 3'(PcPawn)) && (kind <= 3'(PcKing));
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants and the bundled pixel-stream record shared by the video stages.
package vga_pkg;

    localparam int unsigned HCOUNT_W   = 11;
    localparam int unsigned VCOUNT_W   = 11;
    localparam int unsigned RGB_W      = 12;

    // 1024x768 @ 60 Hz timing
    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned HOR_TOTAL  = 1344;
    localparam int unsigned VER_PIXELS = 768;
    localparam int unsigned VER_TOTAL  = 806;

    typedef struct packed {
        logic [VCOUNT_W-1:0] vcount;
        logic                vsync;
        logic                vblnk;
        logic [HCOUNT_W-1:0] hcount;
        logic                hsync;
        logic                hblnk;
        logic [RGB_W-1:0]    rgb;
    } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank flags and colour.
interface vga_if;
    import vga_pkg::*;

    logic [VCOUNT_W-1:0] vcount;
    logic                vsync;
    logic                vblnk;
    logic [HCOUNT_W-1:0] hcount;
    logic                hsync;
    logic                hblnk;
    logic [RGB_W-1:0]    rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/piece_rom.sv
// 32768x1 piece-mask ROM, synchronous read, one cycle latency.
// Address is {type-1, local y, local x}; six 64x64 masks, entries 6 and 7 unused.
module piece_rom (
    input  logic        clk,
    input  logic [14:0] addr,
    output logic        data
);

    // Mask contents: a centred body cut by a per-type diagonal stripe pattern.
    function automatic logic mask_bit(input logic [14:0] a);
        logic [5:0] x;
        logic [5:0] y;
        logic [2:0] t;
        logic [4:0] sum;
        logic       body;
        x    = a[5:0];
        y    = a[11:6];
        t    = a[14:12];
        body = (x >= 6'd12) && (x <= 6'd51) && (y >= 6'd8) && (y <= 6'd55);
        sum  = {1'b0, x[5:2]} + {2'b00, y[5:3]} + {2'b00, t};
        return body && ((sum % 5'd7) != 5'd0);
    endfunction

    // Registered read port
    always_ff @(posedge clk) begin
        data <= mask_bit(addr);
    end

endmodule

// File: rtl/draw_pieces.sv
// Overlays chess pieces and a square highlight on the board video stream.
// Writes go to a shadow board; the active board is refreshed once per frame.
module draw_pieces
    import vga_pkg::*;
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       board_we,
    input  logic [5:0] board_addr,
    input  logic [3:0] board_data,
    input  logic       sel_valid,
    input  logic [5:0] sel_addr,
    vga_if.in          vga_in,
    vga_if.out         vga_out
);

    logic [3:0] shadow [64];
    logic [3:0] active [64];
    logic       vblnk_prev;
    logic       copy_pend;
    logic       sel_valid_r;
    logic [5:0] sel_addr_r;

    vga_sig_t   pix_in;
    logic [8:0] hx;
    logic [8:0] vy;
    logic       in_board;
    logic [5:0] square;
    logic       edge_px;
    logic       sel_hit;

    vga_sig_t   s1_sig;
    logic       s1_in_board;
    logic       s1_sel_hit;
    logic [3:0] s1_piece;
    logic [5:0] s1_lx;
    logic [5:0] s1_ly;

    vga_sig_t   s2_sig;
    logic       s2_in_board;
    logic       s2_sel_hit;
    logic       s2_piece_on;
    logic       s2_black;
    logic       mask;
    logic [14:0] rom_addr;

    vga_sig_t   out_d;
    vga_sig_t   out_q;

    // Detect vblnk rising edge; the copy fires one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            copy_pend  <= 1'b0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            copy_pend  <= vga_in.vblnk & ~vblnk_prev;
        end
    end

    // Shadow board write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) shadow[i] <= START_POS[i];
        end else if (board_we) begin
            shadow[board_addr] <= board_data;
        end
    end

    // Frame-synchronous copy; a write in the copy cycle reaches only the shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) active[i] <= START_POS[i];
            sel_valid_r <= 1'b0;
            sel_addr_r  <= 6'd0;
        end else if (copy_pend) begin
            for (int i = 0; i < 64; i++) active[i] <= shadow[i];
            sel_valid_r <= sel_valid;
            sel_addr_r  <= sel_addr;
        end
    end

    // S1 decode: board coordinates and highlight border test
    always_comb begin
        pix_in.vcount = vga_in.vcount;
        pix_in.vsync  = vga_in.vsync;
        pix_in.vblnk  = vga_in.vblnk;
        pix_in.hcount = vga_in.hcount;
        pix_in.hsync  = vga_in.hsync;
        pix_in.hblnk  = vga_in.hblnk;
        pix_in.rgb    = vga_in.rgb;
        hx       = 9'(vga_in.hcount - 11'(BOARD_X0));
        vy       = 9'(vga_in.vcount - 11'(BOARD_Y0));
        in_board = (vga_in.hcount >= 11'(BOARD_X0))
                && (vga_in.hcount <  11'(BOARD_X0 + BOARD_SIZE))
                && (vga_in.vcount >= 11'(BOARD_Y0))
                && (vga_in.vcount <  11'(BOARD_Y0 + BOARD_SIZE));
        square   = {vy[8:6], hx[8:6]};
        // Two-pixel frame: local coordinate in {0,1,62,63}
        edge_px  = (hx[5:1] == 5'b00000) || (hx[5:1] == 5'b11111)
                || (vy[5:1] == 5'b00000) || (vy[5:1] == 5'b11111);
        sel_hit  = sel_valid_r && (square == sel_addr_r) && edge_px;
    end

    // S1 register: piece lookup and delayed stream
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sig      <= '0;
            s1_in_board <= 1'b0;
            s1_sel_hit  <= 1'b0;
            s1_piece    <= 4'd0;
            s1_lx       <= 6'd0;
            s1_ly       <= 6'd0;
        end else begin
            s1_sig      <= pix_in;
            s1_in_board <= in_board;
            s1_sel_hit  <= sel_hit;
            s1_piece    <= active[square];
            s1_lx       <= hx[5:0];
            s1_ly       <= vy[5:0];
        end
    end

    assign rom_addr = {s1_piece[2:0] - 3'd1, s1_ly, s1_lx};

    piece_rom u_piece_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (mask)
    );

    // S2 register: stage alongside the ROM read
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sig      <= '0;
            s2_in_board <= 1'b0;
            s2_sel_hit  <= 1'b0;
            s2_piece_on <= 1'b0;
            s2_black    <= 1'b0;
        end else begin
            s2_sig      <= s1_sig;
            s2_in_board <= s1_in_board;
            s2_sel_hit  <= s1_sel_hit;
            s2_piece_on <= is_piece(s1_piece[2:0]);
            s2_black    <= s1_piece[BLACK_BIT];
        end
    end

    // S3 colour select: blank/outside, highlight, piece, background
    always_comb begin
        out_d = s2_sig;
        if (s2_sig.hblnk || s2_sig.vblnk || !s2_in_board) begin
            out_d.rgb = s2_sig.rgb;
        end else if (s2_sel_hit) begin
            out_d.rgb = 12'hF00;
        end else if (s2_piece_on && mask) begin
            out_d.rgb = s2_black ? 12'h000 : 12'hFFF;
        end
    end

    // S3 output register
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign vga_out.vcount = out_q.vcount;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.hcount = out_q.hcount;
    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_pieces.sv
// Self-checking bench for draw_pieces with a frame-level reference model.
module tb_draw_pieces;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       board_we;
    logic [5:0] board_addr;
    logic [3:0] board_data;
    logic       sel_valid;
    logic [5:0] sel_addr;

    vga_if vin ();
    vga_if vout ();

    draw_pieces u_dut (
        .clk        (clk),
        .rst        (rst),
        .board_we   (board_we),
        .board_addr (board_addr),
        .board_data (board_data),
        .sel_valid  (sel_valid),
        .sel_addr   (sel_addr),
        .vga_in     (vin),
        .vga_out    (vout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [3:0] m_shadow [64];
    logic [3:0] m_active [64];
    logic       m_sel_v;
    logic [5:0] m_sel_a;
    logic       m_prev_vb;
    logic       m_copy;
    vga_sig_t   m_exp [3];
    int         back_row [8] = '{4, 2, 3, 5, 6, 3, 2, 4};

    function automatic logic [3:0] start_code(input int idx);
        int r;
        int c;
        r = idx / 8;
        c = idx % 8;
        if (r == 0) return 4'(back_row[c] + 8);
        if (r == 1) return 4'd9;
        if (r == 6) return 4'd1;
        if (r == 7) return 4'(back_row[c]);
        return 4'd0;
    endfunction

    function automatic logic ref_mask(input int typ, input int x, input int y);
        int t;
        t = typ - 1;
        return (x >= 12 && x <= 51 && y >= 8 && y <= 55) && (((x / 4) + (y / 8) + t) % 7 != 0);
    endfunction

    function automatic vga_sig_t cur_in();
        vga_sig_t p;
        p.vcount = vin.vcount;
        p.vsync  = vin.vsync;
        p.vblnk  = vin.vblnk;
        p.hcount = vin.hcount;
        p.hsync  = vin.hsync;
        p.hblnk  = vin.hblnk;
        p.rgb    = vin.rgb;
        return p;
    endfunction

    function automatic vga_sig_t obs();
        vga_sig_t p;
        p.vcount = vout.vcount;
        p.vsync  = vout.vsync;
        p.vblnk  = vout.vblnk;
        p.hcount = vout.hcount;
        p.hsync  = vout.hsync;
        p.hblnk  = vout.hblnk;
        p.rgb    = vout.rgb;
        return p;
    endfunction

    function automatic vga_sig_t ref_pixel(input vga_sig_t p);
        vga_sig_t e;
        int h, v, lx, ly, sq, typ;
        logic [3:0] code;
        e = p;
        h = int'(p.hcount);
        v = int'(p.vcount);
        if (p.hblnk || p.vblnk) return e;
        if (h < 256 || h > 767 || v < 128 || v > 639) return e;
        lx = (h - 256) % 64;
        ly = (v - 128) % 64;
        sq = ((v - 128) / 64) * 8 + (h - 256) / 64;
        if (m_sel_v && int'(m_sel_a) == sq && (lx < 2 || lx > 61 || ly < 2 || ly > 61)) begin
            e.rgb = 12'hF00;
        end else begin
            code = m_active[sq];
            typ  = int'(code) % 8;
            if (typ >= 1 && typ <= 6 && ref_mask(typ, lx, ly))
                e.rgb = (code >= 4'd8) ? 12'h000 : 12'hFFF;
        end
        return e;
    endfunction

    // One clock: model consumes the inputs present at the edge, then returns at negedge
    task automatic cycle();
        vga_sig_t e;
        @(posedge clk);
        e = ref_pixel(cur_in());
        if (rst) begin
            for (int i = 0; i < 3; i++) m_exp[i] = '0;
            for (int i = 0; i < 64; i++) begin
                m_shadow[i] = start_code(i);
                m_active[i] = start_code(i);
            end
            m_sel_v   = 1'b0;
            m_sel_a   = 6'd0;
            m_prev_vb = 1'b0;
            m_copy    = 1'b0;
        end else begin
            m_exp[2] = m_exp[1];
            m_exp[1] = m_exp[0];
            m_exp[0] = e;
            if (m_copy) begin
                for (int i = 0; i < 64; i++) m_active[i] = m_shadow[i];
                m_sel_v = sel_valid;
                m_sel_a = sel_addr;
            end
            if (board_we) m_shadow[board_addr] = board_data;
            m_copy    = vin.vblnk && !m_prev_vb;
            m_prev_vb = vin.vblnk;
        end
        @(negedge clk);
    endtask

    task automatic set_pixel(input int h, input int v, input logic [11:0] rgb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.hsync  = 1'($urandom_range(0, 1));
        vin.vsync  = 1'($urandom_range(0, 1));
        vin.rgb    = rgb;
    endtask

    task automatic frame_edge();
        vin.vblnk  = 1'b1;
        vin.vcount = 11'd700;
        repeat (3) cycle();
        vin.vblnk = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        logic [11:0] r;
        rst = 1'b1;
        vin.hcount = 11'($urandom_range(0, 1023));
        vin.vcount = 11'($urandom_range(0, 767));
        vin.rgb    = 12'($urandom);
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs() !== '0) begin
                failures++;
                $display("FAIL reset_zero got=%h exp=0", obs());
            end
        end
        rst = 1'b0;
        r = 12'h5A5;
        set_pixel(288, 160, r);
        repeat (3) cycle();
        checks++;
        if (vout.rgb !== 12'h000) begin
            failures++;
            $display("FAIL reset_rook_rgb got=%h exp=000", vout.rgb);
        end
        checks++;
        if (obs() !== m_exp[2]) begin
            failures++;
            $display("FAIL reset_rook_all got=%h exp=%h", obs(), m_exp[2]);
        end
    endtask

    task automatic test_mid_reset();
        board_we = 1'b1; board_addr = 6'd0; board_data = 4'd0;
        set_pixel(300, 300, 12'h123);
        cycle();
        board_we = 1'b0;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        frame_edge();
        set_pixel(288, 160, 12'h3C3);
        repeat (3) cycle();
        checks++;
        if (vout.rgb !== 12'h000 || obs() !== m_exp[2]) begin
            failures++;
            $display("FAIL mid_reset_restore got=%h exp=%h", obs(), m_exp[2]);
        end
    endtask

    task automatic test_frame_update();
        logic [11:0] r;
        r = 12'h246;
        set_pixel(544, 416, r);
        repeat (3) cycle();
        board_we = 1'b1; board_addr = 6'd36; board_data = 4'd5;
        cycle();
        board_we = 1'b0;
        repeat (3) cycle();
        checks++;
        if (vout.rgb !== r || obs() !== m_exp[2]) begin
            failures++;
            $display("FAIL frame_hold got=%h exp_rgb=%h", obs(), r);
        end
        frame_edge();
        set_pixel(544, 416, r);
        repeat (3) cycle();
        checks++;
        if (vout.rgb !== 12'hFFF || obs() !== m_exp[2]) begin
            failures++;
            $display("FAIL frame_queen got=%h exp_rgb=FFF", obs());
        end
    endtask

    task automatic test_write_copy();
        logic [11:0] r;
        r = 12'h9AB;
        vin.vblnk = 1'b1;
        cycle();
        board_we = 1'b1; board_addr = 6'd0; board_data = 4'd0;
        cycle();
        board_we = 1'b0;
        vin.vblnk = 1'b0;
        cycle();
        set_pixel(288, 160, r);
        repeat (3) cycle();
        checks++;
        if (vout.rgb !== 12'h000 || obs() !== m_exp[2]) begin
            failures++;
            $display("FAIL copy_write_old got=%h exp_rgb=000", obs());
        end
        frame_edge();
        set_pixel(288, 160, r);
        repeat (3) cycle();
        checks++;
        if (vout.rgb !== r || obs() !== m_exp[2]) begin
            failures++;
            $display("FAIL copy_write_new got=%h exp_rgb=%h", obs(), r);
        end
    endtask

    task automatic test_highlight();
        int hs [5] = '{704, 767, 730, 730, 730};
        int vs [5] = '{600, 600, 576, 577, 600};
        sel_valid = 1'b1;
        sel_addr  = 6'd63;
        frame_edge();
        for (int i = 0; i < 5; i++) begin
            set_pixel(hs[i], vs[i], 12'h0F0);
            repeat (3) cycle();
            checks++;
            if ((i < 4 && vout.rgb !== 12'hF00) || obs() !== m_exp[2]) begin
                failures++;
                $display("FAIL highlight_%0d got=%h exp=%h", i, obs(), m_exp[2]);
            end
        end
    endtask

    task automatic test_edges();
        int hs [6] = '{255, 768, 300, 300, 767, 256};
        int vs [6] = '{300, 300, 127, 640, 639, 128};
        for (int i = 0; i < 64; i++) begin
            board_we = 1'b1; board_addr = 6'(i); board_data = 4'd0;
            cycle();
        end
        board_we  = 1'b0;
        sel_valid = 1'b1;
        sel_addr  = 6'd0;
        frame_edge();
        for (int i = 0; i < 6; i++) begin
            set_pixel(hs[i], vs[i], 12'h888);
            repeat (3) cycle();
            checks++;
            if ((i < 5 && vout.rgb !== 12'h888) || (i == 5 && vout.rgb !== 12'hF00)
                || obs() !== m_exp[2]) begin
                failures++;
                $display("FAIL edge_%0d got=%h exp=%h", i, obs(), m_exp[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            vin.hcount = 11'($urandom_range(200, 830));
            vin.vcount = 11'($urandom_range(100, 680));
            vin.hblnk  = ($urandom_range(0, 15) == 0);
            vin.vblnk  = ($urandom_range(0, 24) == 0);
            vin.hsync  = 1'($urandom_range(0, 1));
            vin.vsync  = 1'($urandom_range(0, 1));
            vin.rgb    = 12'($urandom);
            board_we   = ($urandom_range(0, 3) == 0);
            board_addr = 6'($urandom);
            board_data = 4'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                sel_valid = 1'($urandom_range(0, 1));
                sel_addr  = 6'($urandom);
            end
            cycle();
            checks++;
            if (obs() !== m_exp[2]) begin
                failures++;
                $display("FAIL random_%0d got=%h exp=%h", n, obs(), m_exp[2]);
            end
        end
        board_we = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        board_we   = 1'b0;
        board_addr = 6'd0;
        board_data = 4'd0;
        sel_valid  = 1'b0;
        sel_addr   = 6'd0;
        vin.hcount = 11'd0;
        vin.vcount = 11'd0;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
        vin.rgb    = 12'd0;
        for (int i = 0; i < 3; i++) m_exp[i] = '0;
        @(negedge clk);
        test_reset();
        test_mid_reset();
        test_frame_update();
        test_write_copy();
        test_highlight();
        test_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
